ps2_rx_frame: RTL and testbench

PS/2 device-to-host frame receiver, directly upstream of the PS/2 peripheral's RX FIFO and SPI wrapper. Samples the open-drain ps2_clk/ps2_dat lines and synchronizes them into clk. Decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Emits one byte per frame with error qualifiers and recovers from stalled or truncated frames via an inter-edge watchdog.

---
 rtl/ps2_rx_frame.sv | 143 ++++++++++++++
 tb/tb_ps2_rx_frame.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: line sync, falling-edge decode of 11-bit frames, inter-edge watchdog.
// Optional ps2_clk glitch filter enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_rx_frame #(
  parameter int FCLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US  = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  input  logic       en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_timeout,
  output logic       busy
);
  localparam int TIMEOUT_CYCLES = FCLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s, clk_f, clk_prev, fall;
  logic [1:0]             state;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par_bit, stop_bit, done;
  logic [WD_W-1:0]        wd_cnt;
  logic                   wd_expire;

  // Synchronizers idle at the released open-drain level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_i};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;

  // Output follows the input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_f   <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
`else
  assign clk_f = clk_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev <= 1'b1;
    else        clk_prev <= clk_f;
  end

  assign fall      = clk_prev & ~clk_f;
  assign wd_expire = (state != S_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      bitcnt        <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      stop_bit      <= 1'b0;
      done          <= 1'b0;
      wd_cnt        <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_timeout    <= 1'b0;
    end else begin
      // Frame results are presented the cycle after the stop edge
      done          <= 1'b0;
      rx_timeout    <= 1'b0;
      rx_valid      <= done;
      rx_parity_err <= done & ~(^shreg ^ par_bit);
      rx_frame_err  <= done & ~stop_bit;
      if (done) rx_data <= shreg;

      if (state == S_IDLE || fall || wd_expire) wd_cnt <= '0;
      else                                      wd_cnt <= wd_cnt + 1'b1;

      // Enable drop beats an edge, an edge beats an expiring watchdog
      if (state != S_IDLE && !en) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (fall) begin
        case (state)
          S_IDLE: if (!dat_s && en) begin
            state  <= S_DATA;
            busy   <= 1'b1;
            bitcnt <= '0;
          end
          S_DATA: begin
            shreg  <= {dat_s, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= S_PAR;
          end
          S_PAR: begin
            par_bit <= dat_s;
            state   <= S_STOP;
          end
          default: begin
            stop_bit <= dat_s;
            done     <= 1'b1;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end
        endcase
      end else if (wd_expire) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        rx_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: 50 MHz clk, 10 us watchdog (500 cycles), fast 100-cycle ps2_clk period.
module tb_ps2_rx_frame;
  localparam int H = 50;
`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FLX = 8;
`else
  localparam int FLX = 0;
`endif

  logic       clk, rst_n, ps2_clk_i, ps2_dat_i, en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_timeout, busy;

  int vectors = 0;
  int fails   = 0;
  int nvalid  = 0;
  int ntmo    = 0;
  int nleak   = 0;

  ps2_rx_frame #(
    .FCLK_HZ(50_000_000), .TIMEOUT_US(10), .SYNC_STAGES(2), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i), .en(en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_timeout(rx_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) nvalid++;
    if (rx_timeout) ntmo++;
    if (!rx_valid && (rx_parity_err || rx_frame_err)) nleak++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_dat_i = b;
    tick(H);
    ps2_clk_i = 1'b0;
    tick(H);
    ps2_clk_i = 1'b1;
  endtask

  // Full frame; checks exact rx_valid latency and the qualifiers on the pulse
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic exp_perr, input logic exp_ferr, input string tag);
    int nv0;
    nv0 = nvalid;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    ps2_dat_i = stp;
    tick(H);
    ps2_clk_i = 1'b0;
    tick(3 + FLX);
    check({tag, "_early"}, {31'd0, rx_valid}, 32'd0);
    tick(1);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"},  {24'd0, rx_data}, {24'd0, d});
    check({tag, "_perr"},  {31'd0, rx_parity_err}, {31'd0, exp_perr});
    check({tag, "_ferr"},  {31'd0, rx_frame_err}, {31'd0, exp_ferr});
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    tick(H - 4 - FLX);
    ps2_clk_i = 1'b1;
    tick(H);
    check({tag, "_npulse"}, nvalid - nv0, 32'd1);
  endtask

  initial begin
    int nv0, nt0, to_at;
    rst_n = 1'b0; ps2_clk_i = 1'b1; ps2_dat_i = 1'b1; en = 1'b1;
    tick(5);
    check("reset_outs", {18'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_timeout, busy}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "a5");
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, "3c_par");
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "00_stop");

    // Watchdog: start + 4 data bits, then the line stalls high
    nv0 = nvalid; nt0 = ntmo; to_at = 0;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2_dat_i = 1'b1;
    tick(H);
    ps2_clk_i = 1'b0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (i == H) ps2_clk_i = 1'b1;
      if (rx_timeout && to_at == 0) to_at = i;
    end
    check("tmo_cycle", to_at, 504 + FLX);
    check("tmo_count", ntmo - nt0, 32'd1);
    check("tmo_novalid", nvalid - nv0, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_data_held", {24'd0, rx_data}, 32'h00);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, "5a");

    // Enable drop after bit 3
    nv0 = nvalid; nt0 = ntmo;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("en_busy_before", {31'd0, busy}, 32'd1);
    en = 1'b0;
    tick(1);
    check("en_busy_after", {31'd0, busy}, 32'd0);
    tick(600);
    check("en_novalid", nvalid - nv0, 32'd0);
    check("en_notmo", ntmo - nt0, 32'd0);
    en = 1'b1;
    tick(5);

    // Reset mid-frame
    nv0 = nvalid;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {18'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_timeout, busy}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("mid_novalid", nvalid - nv0, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, "81");

    // Short low glitch on ps2_clk in IDLE with data low
    ps2_dat_i = 1'b0;
    ps2_clk_i = 1'b0;
    tick(3);
    ps2_clk_i = 1'b1;
    tick(20 + FLX);
`ifdef PS2_RX_GLITCH_FILTER_EN
    check("glitch_busy", {31'd0, busy}, 32'd0);
`else
    check("glitch_busy", {31'd0, busy}, 32'd1);
    en = 1'b0;
    tick(2);
    check("glitch_recover", {31'd0, busy}, 32'd0);
    en = 1'b1;
    tick(2);
`endif
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "a5_post");

    check("flag_leak", nleak, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
